// File: rtl/full_adder_2_half_adder.sv
`timescale 1ns/1ps
// Half adder leaf cell: sum and carry of two bits.
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/full_adder_2.sv
`timescale 1ns/1ps
// Single-bit full adder from two half adders and an OR gate, with a registered
// copy of {c_out, s} for clocked datapaths.
module full_adder_2 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic c_out,
  input  logic clk,
  input  logic rst,
  output logic s_q,
  output logic c_out_q
);

  logic p;
  logic g1;
  logic g2;

  half_adder u_ha_ab (
    .x     (a),
    .y     (b),
    .sum   (p),
    .carry (g1)
  );

  half_adder u_ha_pc (
    .x     (p),
    .y     (c),
    .sum   (s),
    .carry (g2)
  );

  // The two generate terms are mutually exclusive, so OR completes the carry.
  assign c_out = g1 | g2;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      s_q     <= s;
      c_out_q <= c_out;
    end
  end

endmodule

// File: tb/tb_full_adder_2.sv
`timescale 1ns/1ps
// Directed and random checks of the full adder's combinational and registered paths.
module tb_full_adder_2;

  logic a, b, c;
  logic s, c_out;
  logic clk = 1'b0;
  logic rst;
  logic s_q, c_out_q;

  int n_checks = 0;
  int n_pass   = 0;

  full_adder_2 dut (
    .a       (a),
    .b       (b),
    .c       (c),
    .s       (s),
    .c_out   (c_out),
    .clk     (clk),
    .rst     (rst),
    .s_q     (s_q),
    .c_out_q (c_out_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
  endtask

  // Expected outputs for abc = 0..7, bit i belongs to vector i.
  logic [7:0] exp_s    = 8'b1001_0110;
  logic [7:0] exp_cout = 8'b1110_1000;

  initial begin
    rst = 1'b1;
    {a, b, c} = 3'b000;
    #1;
    check("reset_q", {c_out_q, s_q}, 2'b00);

    // Exhaustive combinational sweep at 1 ns spacing.
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      check($sformatf("sweep_%0d", i), {c_out, s}, {exp_cout[i], exp_s[i]});
    end
    check("reset_hold_q", {c_out_q, s_q}, 2'b00);

    // Registered path.
    @(negedge clk);
    rst = 1'b0;
    {a, b, c} = 3'b111;
    @(posedge clk); #1;
    check("reg_111", {c_out_q, s_q}, 2'b11);
    @(negedge clk);
    {a, b, c} = 3'b010;
    #1;
    check("reg_hold", {c_out_q, s_q}, 2'b11);
    check("comb_010", {c_out, s}, 2'b01);
    @(posedge clk); #1;
    check("reg_010", {c_out_q, s_q}, 2'b01);

    // Asynchronous reset between edges.
    @(negedge clk);
    {a, b, c} = 3'b111;
    @(posedge clk); #1;
    check("reg_pre_rst", {c_out_q, s_q}, 2'b11);
    #2;
    rst = 1'b1;
    #0.1;
    check("async_rst_q", {c_out_q, s_q}, 2'b00);
    check("async_rst_comb", {c_out, s}, 2'b11);

    // Reset rising in the same time step as a clock edge.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reg_reload", {c_out_q, s_q}, 2'b11);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("coincident_rst", {c_out_q, s_q}, 2'b00);
    @(posedge clk); #1;
    check("rst_held", {c_out_q, s_q}, 2'b00);

    // Release of reset.
    @(negedge clk);
    {a, b, c} = 3'b101;
    rst = 1'b0;
    #1;
    check("release_hold", {c_out_q, s_q}, 2'b00);
    @(posedge clk); #1;
    check("release_load", {c_out_q, s_q}, 2'b10);

    // Random arithmetic check.
    for (int i = 0; i < 1000; i++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      {a, b, c} = v;
      #1;
      check("random", {c_out, s}, 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
